// File: rtl/aes_cipher_client.sv
// ============================================================================
// Module   : aes_cipher_client
// Purpose  : Single-job initiator for the AES cipher core. It runs decrypt-key
//            generation when a decrypt job needs it, then the crypt request,
//            and returns the result state together with an error flag.
// Options  : AES_CLIENT_KEY_CACHE_EN keeps the key of the last successful
//            dec-key-gen so that repeat decrypts skip key generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cipher_client #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         blk_req_valid_i,
    output logic         blk_req_ready_o,
    input  logic         blk_op_i,
    input  logic [2:0]   blk_key_len_i,
    input  logic [255:0] blk_key_i,
    input  logic [127:0] blk_data_i,
    output logic         blk_res_valid_o,
    input  logic         blk_res_ready_i,
    output logic [127:0] blk_res_data_o,
    output logic         blk_res_err_o,
    output logic         core_dec_key_gen_valid_o,
    input  logic         core_dec_key_gen_ack_i,
    output logic         core_dec_key_gen_data_o,
    input  logic         core_dec_key_gen_res_valid_i,
    input  logic         core_dec_key_gen_res_data_i,
    output logic         core_crypt_valid_o,
    input  logic         core_crypt_ack_i,
    output logic [127:0] core_crypt_data_o,
    output logic [255:0] core_key_pack_o,
    output logic [2:0]   core_key_len_o,
    output logic [5:0]   core_ctrl_o,
    input  logic         core_crypt_res_valid_i,
    output logic         core_crypt_res_ack_o,
    input  logic [257:0] core_crypt_res_data_i
);

    localparam int              c_tw   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tw-1:0] c_tmax = c_tw'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_kg_req  = 3'd1;
    localparam logic [2:0] c_kg_wait = 3'd2;
    localparam logic [2:0] c_cr_req  = 3'd3;
    localparam logic [2:0] c_cr_wait = 3'd4;
    localparam logic [2:0] c_resp    = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [c_tw-1:0] r_timer;
    logic [1:0]      r_ctrl_op;
    logic [255:0]    r_key;
    logic [2:0]      r_key_len;
    logic [127:0]    r_data;
    logic [127:0]    r_res_data;
    logic            r_res_err;
    logic            r_err;

    logic w_accept;
    logic w_timer_done;
    logic w_timeout_hit;
    logic w_core_state;
    logic w_kg_done;
    logic w_cr_done;
    logic w_cr_err;
    logic w_cache_hit;
    logic w_unused;

    assign w_accept     = blk_req_valid_i & blk_req_ready_o;
    assign w_timer_done = (r_timer == c_tmax);
    assign w_core_state = (r_state == c_kg_req) | (r_state == c_kg_wait) |
                          (r_state == c_cr_req) | (r_state == c_cr_wait);
    assign w_kg_done    = (r_state == c_kg_wait) & core_dec_key_gen_res_valid_i;
    assign w_cr_done    = (r_state == c_cr_wait) & core_crypt_res_valid_i;
    assign w_cr_err     = core_crypt_res_data_i[129] | r_err;
    assign w_unused     = ^{core_crypt_res_data_i[257:130], core_crypt_res_data_i[128]};

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_idle;
        else       r_state <= w_next;
    end

    // A same-cycle ack/result wins over an expiring timer.
    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_accept) w_next = (blk_op_i && !w_cache_hit) ? c_kg_req : c_cr_req;
            end
            c_kg_req: begin
                if (core_dec_key_gen_ack_i) w_next = c_kg_wait;
                else if (w_timer_done) begin w_next = c_resp; w_timeout_hit = 1'b1; end
            end
            c_kg_wait: begin
                if (core_dec_key_gen_res_valid_i) w_next = c_cr_req;
                else if (w_timer_done) begin w_next = c_resp; w_timeout_hit = 1'b1; end
            end
            c_cr_req: begin
                if (core_crypt_ack_i) w_next = c_cr_wait;
                else if (w_timer_done) begin w_next = c_resp; w_timeout_hit = 1'b1; end
            end
            c_cr_wait: begin
                if (core_crypt_res_valid_i) w_next = c_resp;
                else if (w_timer_done) begin w_next = c_resp; w_timeout_hit = 1'b1; end
            end
            c_resp: begin
                if (blk_res_ready_i) w_next = c_idle;
            end
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer    <= '0;
            r_ctrl_op  <= 2'b00;
            r_key      <= '0;
            r_key_len  <= '0;
            r_data     <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_timer <= (w_core_state && (w_next == r_state)) ? r_timer + 1'b1 : '0;
            if (w_accept) begin
                r_ctrl_op <= blk_op_i ? 2'b10 : 2'b01;
                r_key     <= blk_key_i;
                r_key_len <= blk_key_len_i;
                r_data    <= blk_data_i;
                r_err     <= 1'b0;
            end
            if (w_kg_done) r_err <= r_err | core_dec_key_gen_res_data_i;
            if (w_cr_done) begin
                r_res_data <= w_cr_err ? 128'd0 : core_crypt_res_data_i[127:0];
                r_res_err  <= w_cr_err;
            end
            if (w_timeout_hit) begin
                r_res_data <= '0;
                r_res_err  <= 1'b1;
            end
        end
    end

`ifdef AES_CLIENT_KEY_CACHE_EN
    logic         r_cache_valid;
    logic [255:0] r_cache_key;
    logic [2:0]   r_cache_len;

    assign w_cache_hit = r_cache_valid &&
                         ({r_cache_key, r_cache_len} == {blk_key_i, blk_key_len_i});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cache_valid <= 1'b0;
            r_cache_key   <= '0;
            r_cache_len   <= '0;
        end else if (w_kg_done && !core_dec_key_gen_res_data_i) begin
            r_cache_valid <= 1'b1;
            r_cache_key   <= r_key;
            r_cache_len   <= r_key_len;
        end else if (w_kg_done || w_timeout_hit || (w_cr_done && w_cr_err)) begin
            r_cache_valid <= 1'b0;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    assign blk_req_ready_o          = (r_state == c_idle) & ~rst_i;
    assign blk_res_valid_o          = (r_state == c_resp);
    assign blk_res_data_o           = r_res_data;
    assign blk_res_err_o            = r_res_err;
    assign core_dec_key_gen_valid_o = (r_state == c_kg_req);
    assign core_dec_key_gen_data_o  = 1'b1;
    assign core_crypt_valid_o       = (r_state == c_cr_req);
    assign core_crypt_data_o        = r_data;
    assign core_key_pack_o          = r_key;
    assign core_key_len_o           = r_key_len;
    assign core_ctrl_o              = {3'b000, 1'b1, r_ctrl_op};
    // Results arriving outside CR_WAIT are acked too, so a stale core drains.
    assign core_crypt_res_ack_o     = core_crypt_res_valid_i & ~rst_i;

endmodule

`default_nettype wire

// File: tb/tb_aes_cipher_client.sv
// ============================================================================
// Module   : tb_aes_cipher_client
// Purpose  : Self-checking bench for aes_cipher_client with a scripted core
//            stub and a job-level reference model of results and key cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_cipher_client;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_req_valid, blk_req_ready, blk_op;
    logic [2:0]   blk_key_len;
    logic [255:0] blk_key;
    logic [127:0] blk_data;
    logic         blk_res_valid, blk_res_ready, blk_res_err;
    logic [127:0] blk_res_data;
    logic         kg_valid, kg_ack, kg_data, kg_res_valid, kg_res_data;
    logic         cr_valid, cr_ack, cr_res_valid, cr_res_ack;
    logic [127:0] cr_data;
    logic [255:0] key_pack;
    logic [2:0]   key_len;
    logic [5:0]   ctrl;
    logic [257:0] cr_res_data;

    aes_cipher_client #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .blk_req_valid_i(blk_req_valid), .blk_req_ready_o(blk_req_ready),
        .blk_op_i(blk_op), .blk_key_len_i(blk_key_len), .blk_key_i(blk_key),
        .blk_data_i(blk_data),
        .blk_res_valid_o(blk_res_valid), .blk_res_ready_i(blk_res_ready),
        .blk_res_data_o(blk_res_data), .blk_res_err_o(blk_res_err),
        .core_dec_key_gen_valid_o(kg_valid), .core_dec_key_gen_ack_i(kg_ack),
        .core_dec_key_gen_data_o(kg_data),
        .core_dec_key_gen_res_valid_i(kg_res_valid),
        .core_dec_key_gen_res_data_i(kg_res_data),
        .core_crypt_valid_o(cr_valid), .core_crypt_ack_i(cr_ack),
        .core_crypt_data_o(cr_data), .core_key_pack_o(key_pack),
        .core_key_len_o(key_len), .core_ctrl_o(ctrl),
        .core_crypt_res_valid_i(cr_res_valid), .core_crypt_res_ack_o(cr_res_ack),
        .core_crypt_res_data_i(cr_res_data)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   kg_eps = 0;
    logic kg_prev = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        kg_prev <= kg_valid;
        if (kg_valid && !kg_prev) kg_eps <= kg_eps + 1;
    end

    // Reference model of the key cache: which {key,len} a decrypt may reuse.
    bit           cache_en;
    bit           m_valid = 1'b0;
    logic [255:0] m_key;
    logic [2:0]   m_len;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic op, input logic [2:0] len,
                           input logic [255:0] key, input logic [127:0] data,
                           input logic [127:0] cres, input logic kg_alert, input logic cr_alert,
                           input int ack_w, input int res_w, input int rdy_w, input logic no_ack);
        logic         exp_kg, exp_err;
        logic [127:0] exp_data;
        int           t0, eps0, n, lat;
        bit           got;
        exp_kg   = op && !(cache_en && m_valid && m_key == key && m_len == len);
        exp_err  = no_ack | (exp_kg & kg_alert) | cr_alert;
        exp_data = exp_err ? 128'd0 : cres;
        lat      = 3 + ack_w + res_w + (exp_kg ? ack_w + res_w + 2 : 0);
        eps0     = kg_eps;
        @(negedge clk);
        blk_req_valid = 1'b1; blk_op = op; blk_key_len = len; blk_key = key; blk_data = data;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (blk_req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check({tag, ":req_ready"}, got, 1);
        t0 = cyc;
        @(negedge clk);
        blk_req_valid = 1'b0;
        check({tag, ":kg_valid"}, kg_valid, exp_kg);
        if (exp_kg) begin
            check({tag, ":kg_key"}, key_pack, key);
            check({tag, ":kg_data"}, kg_data, 1);
            repeat (ack_w) @(negedge clk);
            check({tag, ":kg_hold"}, kg_valid, 1);
            kg_ack = 1'b1;
            @(negedge clk);
            kg_ack = 1'b0;
            check({tag, ":kg_drop"}, kg_valid, 0);
            repeat (res_w) @(negedge clk);
            kg_res_valid = 1'b1; kg_res_data = kg_alert;
            @(negedge clk);
            kg_res_valid = 1'b0; kg_res_data = 1'b0;
        end
        check({tag, ":cr_valid"}, cr_valid, 1);
        check({tag, ":cr_data"}, cr_data, data);
        check({tag, ":cr_key"}, key_pack, key);
        check({tag, ":cr_len"}, key_len, len);
        check({tag, ":ctrl"}, ctrl, op ? 6'b000110 : 6'b000101);
        if (no_ack) begin
            n = 0;
            while (cr_valid && n < 100) begin n++; @(negedge clk); end
            check({tag, ":timeout_cycles"}, n, 16);
        end else begin
            repeat (ack_w) @(negedge clk);
            check({tag, ":cr_hold"}, cr_valid, 1);
            cr_ack = 1'b1;
            @(negedge clk);
            cr_ack = 1'b0;
            check({tag, ":cr_drop"}, cr_valid, 0);
            repeat (res_w) @(negedge clk);
            cr_res_valid = 1'b1;
            cr_res_data  = {128'hdead_beef, 1'b0, cr_alert, 1'b1, cres};
            #1 check({tag, ":res_ack"}, cr_res_ack, 1);
            @(negedge clk);
            cr_res_valid = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (blk_res_valid) begin got = 1; break; end
            @(negedge clk);
        end
        check({tag, ":res_valid"}, got, 1);
        if (!no_ack) check({tag, ":latency"}, cyc - t0, lat);
        check({tag, ":res_data"}, blk_res_data, exp_data);
        check({tag, ":res_err"}, blk_res_err, exp_err);
        for (int i = 0; i < rdy_w; i++) begin
            @(negedge clk);
            blk_req_valid = 1'b1;
            #1 check({tag, ":hold_ready0"}, blk_req_ready, 0);
            check({tag, ":hold_data"}, {blk_res_valid, blk_res_err, blk_res_data}, {1'b1, exp_err, exp_data});
        end
        blk_res_ready = 1'b1;
        @(negedge clk);
        blk_res_ready = 1'b0; blk_req_valid = 1'b0;
        check({tag, ":res_drop"}, blk_res_valid, 0);
        check({tag, ":kg_episodes"}, kg_eps - eps0, exp_kg);
        if (exp_kg && !kg_alert) begin m_valid = 1'b1; m_key = key; m_len = len; end
        if (exp_err) m_valid = 1'b0;
    endtask

    localparam logic [255:0] FIPS_KEY = {128'd0, 128'h0f0e0d0c_0b0a0908_07060504_03020100};
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [255:0] pool [2];
    logic [127:0] rd;

    initial begin
`ifdef AES_CLIENT_KEY_CACHE_EN
        cache_en = 1'b1;
`else
        cache_en = 1'b0;
`endif
        rst = 1'b1; blk_req_valid = 0; blk_op = 0; blk_key_len = 0; blk_key = '0; blk_data = '0;
        blk_res_ready = 0; kg_ack = 0; kg_res_valid = 0; kg_res_data = 0;
        cr_ack = 0; cr_res_valid = 0; cr_res_data = '0;
        repeat (3) @(negedge clk);
        check("rst:outs", {blk_req_ready, blk_res_valid, blk_res_err, kg_valid, cr_valid, cr_res_ack},
              6'b000000);
        check("rst:ctrl", {kg_data, ctrl}, 7'b1000100);
        check("rst:data", {blk_res_data, cr_data}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst:ready_after", blk_req_ready, 1);

        run_job("fips_enc",  0, 3'd1, FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 0, 0, 0, 0);
        run_job("fips_dec",  1, 3'd1, FIPS_KEY, FIPS_CT, FIPS_PT, 0, 0, 1, 2, 0, 0);
        run_job("fips_dec2", 1, 3'd1, FIPS_KEY, FIPS_CT, FIPS_PT, 0, 0, 0, 0, 0, 0);
        run_job("hold5",     0, 3'd1, FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 2, 1, 5, 0);
        run_job("timeout",   0, 3'd1, FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, 0, 0, 0, 1);
        run_job("dec_after_to", 1, 3'd1, FIPS_KEY, FIPS_CT, FIPS_PT, 0, 0, 0, 0, 0, 0);
        run_job("dec_cached", 1, 3'd1, FIPS_KEY, FIPS_CT, FIPS_PT, 0, 0, 0, 0, 1, 0);

        // Reset while the core still owes a crypt result.
        @(negedge clk);
        blk_req_valid = 1'b1; blk_op = 0; blk_data = FIPS_PT;
        @(negedge clk);
        blk_req_valid = 1'b0;
        cr_ack = 1'b1;
        @(negedge clk);
        cr_ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_valid = 1'b0;
        cr_res_valid = 1'b1; cr_res_data = {130'd0, FIPS_CT};
        #1 check("rst_mid:stray_ack", cr_res_ack, 1);
        @(negedge clk);
        cr_res_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid:no_res", blk_res_valid, 0);
        end
        run_job("after_rst", 1, 3'd1, FIPS_KEY, FIPS_CT, FIPS_PT, 0, 0, 0, 0, 0, 0);

        pool[0] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pool[1] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < 24; j++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            run_job("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                    pool[$urandom_range(0, 1)], {$urandom, $urandom, $urandom, $urandom}, rd,
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
